// File: rtl/slurm16_bank_scheduler.sv
// rtl/slurm16_bank_scheduler.sv - per-bank CPU/peripheral scheduler for one 16K x 16 BRAM bank
// Optional stall/force statistics are enabled by defining SLURM16_BANK_SCHED_STATS_EN.
module slurm16_bank_scheduler #(
  parameter int BURST_MAX    = 8,
  parameter int CPU_MAX_WAIT = 16
) (
  input  logic        CLK,
  input  logic        RST,
`ifdef SLURM16_BANK_SCHED_STATS_EN
  input  logic        stat_clr,
  output logic [15:0] stat_cpu_stall,
  output logic [7:0]  stat_force,
`endif
  input  logic        cpu_req,
  input  logic [13:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_wr,
  input  logic [1:0]  cpu_mask,
  output logic        cpu_grant,
  input  logic        fl_wvalid,
  input  logic [13:0] fl_addr,
  input  logic [15:0] fl_din,
  output logic        fl_wready,
  input  logic        bg_rvalid,
  input  logic [13:0] bg_addr,
  output logic        bg_rready,
  input  logic        spr_rvalid,
  input  logic [13:0] spr_addr,
  output logic        spr_rready,
  output logic [1:0]  mux_sel,
  output logic [13:0] B_ADDR,
  output logic [15:0] B_DIN,
  output logic [1:0]  B_MASK,
  output logic        B_WR
);

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_FL  = 2'd1;
  localparam logic [1:0] OWN_BG  = 2'd2;
  localparam logic [1:0] OWN_SPR = 2'd3;

  localparam logic [7:0] BURST_LIM = 8'(BURST_MAX);
  localparam logic [7:0] WAIT_LIM  = 8'(CPU_MAX_WAIT);

  typedef enum logic [1:0] {
    S_CPU       = 2'd0,
    S_PERIPH    = 2'd1,
    S_CPU_FORCE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [1:0] mux_n;
  logic [1:0] rr_ptr, rr_n;
  logic [7:0] burst_cnt, burst_n;
  logic [7:0] cpu_wait, cpu_wait_n;
  logic [3:0] vld4, others;
  logic [2:0] pick_idle, pick_rearb;
  logic       owner_valid;

  function automatic logic [1:0] succ(input logic [1:0] own);
    succ = (own == OWN_SPR) ? OWN_FL : own + 2'd1;
  endfunction

  // Returns {found, owner}: first valid peripheral at or after start, cyclic fl->bg->spr.
  function automatic logic [2:0] rr_pick(input logic [1:0] start, input logic [3:0] vld);
    logic [1:0] cand;
    rr_pick = 3'b000;
    cand    = start;
    for (int i = 0; i < 3; i++) begin
      if (!rr_pick[2] && vld[cand]) rr_pick = {1'b1, cand};
      cand = succ(cand);
    end
  endfunction

  always_comb begin
    state_n     = state;
    mux_n       = mux_sel;
    rr_n        = rr_ptr;
    burst_n     = burst_cnt;
    vld4        = {spr_rvalid, bg_rvalid, fl_wvalid, 1'b0};
    others      = vld4;
    others[mux_sel] = 1'b0;
    owner_valid = vld4[mux_sel];
    pick_idle   = rr_pick(rr_ptr, vld4);
    pick_rearb  = rr_pick(succ(mux_sel), others);

    case (state)
      S_CPU, S_CPU_FORCE: begin
        state_n = S_CPU;
        mux_n   = OWN_CPU;
        burst_n = 8'd0;
        if (pick_idle[2]) begin
          state_n = S_PERIPH;
          mux_n   = pick_idle[1:0];
          burst_n = 8'd1;
        end
      end
      S_PERIPH: begin
        if (cpu_wait == WAIT_LIM) begin
          // Forced CPU slot wins over any burst decision; the owner loses its turn.
          state_n = S_CPU_FORCE;
          mux_n   = OWN_CPU;
          rr_n    = succ(mux_sel);
          burst_n = 8'd0;
        end else if (!owner_valid || burst_cnt == BURST_LIM) begin
          rr_n = succ(mux_sel);
          if (pick_rearb[2]) begin
            mux_n   = pick_rearb[1:0];
            burst_n = 8'd1;
          end else begin
            // Lone requester goes back through a CPU cycle before being re-granted.
            state_n = S_CPU;
            mux_n   = OWN_CPU;
            burst_n = 8'd0;
          end
        end else begin
          burst_n = burst_cnt + 8'd1;
        end
      end
      default: begin
        state_n = S_CPU;
        mux_n   = OWN_CPU;
        burst_n = 8'd0;
      end
    endcase
  end

  always_comb begin
    cpu_wait_n = 8'd0;
    if (cpu_req && mux_sel != OWN_CPU)
      cpu_wait_n = (cpu_wait == WAIT_LIM) ? cpu_wait : cpu_wait + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_CPU;
      mux_sel    <= OWN_CPU;
      rr_ptr     <= OWN_FL;
      burst_cnt  <= 8'd0;
      cpu_wait   <= 8'd0;
      cpu_grant  <= 1'b0;
      fl_wready  <= 1'b0;
      bg_rready  <= 1'b0;
      spr_rready <= 1'b0;
    end else begin
      state      <= state_n;
      mux_sel    <= mux_n;
      rr_ptr     <= rr_n;
      burst_cnt  <= burst_n;
      cpu_wait   <= cpu_wait_n;
      cpu_grant  <= (mux_sel == OWN_CPU) && cpu_req;
      fl_wready  <= (mux_sel == OWN_FL)  && fl_wvalid;
      bg_rready  <= (mux_sel == OWN_BG)  && bg_rvalid;
      spr_rready <= (mux_sel == OWN_SPR) && spr_rvalid;
    end
  end

  always_comb begin
    B_ADDR = cpu_addr;
    B_DIN  = cpu_din;
    B_MASK = cpu_mask;
    B_WR   = cpu_wr & cpu_req;
    case (mux_sel)
      OWN_FL: begin
        B_ADDR = fl_addr;
        B_DIN  = fl_din;
        B_MASK = 2'b11;
        B_WR   = fl_wvalid;
      end
      OWN_BG: begin
        B_ADDR = bg_addr;
        B_DIN  = 16'd0;
        B_MASK = 2'b11;
        B_WR   = 1'b0;
      end
      OWN_SPR: begin
        B_ADDR = spr_addr;
        B_DIN  = 16'd0;
        B_MASK = 2'b11;
        B_WR   = 1'b0;
      end
      default: ;
    endcase
  end

`ifdef SLURM16_BANK_SCHED_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST || stat_clr) begin
      stat_cpu_stall <= 16'd0;
      stat_force     <= 8'd0;
    end else begin
      if (cpu_req && mux_sel != OWN_CPU && stat_cpu_stall != 16'hFFFF)
        stat_cpu_stall <= stat_cpu_stall + 16'd1;
      if (state == S_PERIPH && state_n == S_CPU_FORCE)
        stat_force <= stat_force + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_slurm16_bank_scheduler.sv
// tb/tb_slurm16_bank_scheduler.sv - directed self-checking bench for slurm16_bank_scheduler
module tb_slurm16_bank_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_wr;
  logic [1:0]  cpu_mask;
  logic        cpu_grant;
  logic        fl_wvalid;
  logic [13:0] fl_addr;
  logic [15:0] fl_din;
  logic        fl_wready;
  logic        bg_rvalid;
  logic [13:0] bg_addr;
  logic        bg_rready;
  logic        spr_rvalid;
  logic [13:0] spr_addr;
  logic        spr_rready;
  logic [1:0]  mux_sel;
  logic [13:0] B_ADDR;
  logic [15:0] B_DIN;
  logic [1:0]  B_MASK;
  logic        B_WR;
`ifdef SLURM16_BANK_SCHED_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_cpu_stall;
  logic [7:0]  stat_force;
`endif

  int checks = 0;
  int errors = 0;

  slurm16_bank_scheduler #(.BURST_MAX(8), .CPU_MAX_WAIT(16)) dut (
    .CLK(CLK), .RST(RST),
`ifdef SLURM16_BANK_SCHED_STATS_EN
    .stat_clr(stat_clr), .stat_cpu_stall(stat_cpu_stall), .stat_force(stat_force),
`endif
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_wr(cpu_wr),
    .cpu_mask(cpu_mask), .cpu_grant(cpu_grant),
    .fl_wvalid(fl_wvalid), .fl_addr(fl_addr), .fl_din(fl_din), .fl_wready(fl_wready),
    .bg_rvalid(bg_rvalid), .bg_addr(bg_addr), .bg_rready(bg_rready),
    .spr_rvalid(spr_rvalid), .spr_addr(spr_addr), .spr_rready(spr_rready),
    .mux_sel(mux_sel), .B_ADDR(B_ADDR), .B_DIN(B_DIN), .B_MASK(B_MASK), .B_WR(B_WR)
  );

  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs;
    cpu_req = 0; cpu_addr = 14'h0; cpu_din = 16'h0; cpu_wr = 0; cpu_mask = 2'b00;
    fl_wvalid = 0; fl_addr = 14'h0; fl_din = 16'h0;
    bg_rvalid = 0; bg_addr = 14'h0; spr_rvalid = 0; spr_addr = 14'h0;
`ifdef SLURM16_BANK_SCHED_STATS_EN
    stat_clr = 0;
`endif
  endtask

  // Leaves the bench in cycle 0: RST low, DUT in its reset state.
  task automatic do_reset;
    idle_inputs();
    RST = 1;
    tick();
    tick();
    RST = 0;
  endtask

  task automatic test_reset;
    idle_inputs();
    cpu_addr = 14'h0abc;
    RST = 1;
    tick();
    tick();
    checks++;
    if (mux_sel !== 2'd0) begin errors++; $display("FAIL reset_mux got %0d want 0", mux_sel); end
    checks++;
    if ({cpu_grant, fl_wready, bg_rready, spr_rready} !== 4'b0000) begin
      errors++; $display("FAIL reset_acks got %b want 0000", {cpu_grant, fl_wready, bg_rready, spr_rready});
    end
    checks++;
    if (B_ADDR !== 14'h0abc || B_WR !== 1'b0) begin
      errors++; $display("FAIL reset_bank got addr=%h wr=%b want addr=0abc wr=0", B_ADDR, B_WR);
    end
    RST = 0;
    fl_wvalid = 1; spr_rvalid = 1;
    tick();
    checks++;
    if (mux_sel !== 2'd1) begin errors++; $display("FAIL reset_rr_flash got %0d want 1", mux_sel); end
  endtask

  task automatic test_cpu_only;
    do_reset();
    cpu_req = 1; cpu_addr = 14'h0123; cpu_din = 16'hbeef; cpu_wr = 1; cpu_mask = 2'b01;
    #1;
    checks++;
    if (B_ADDR !== 14'h0123 || B_DIN !== 16'hbeef || B_MASK !== 2'b01 || B_WR !== 1'b1) begin
      errors++; $display("FAIL cpu_bank got addr=%h din=%h mask=%b wr=%b want 0123 beef 01 1", B_ADDR, B_DIN, B_MASK, B_WR);
    end
    checks++;
    if (cpu_grant !== 1'b0) begin errors++; $display("FAIL cpu_grant_c0 got %b want 0", cpu_grant); end
    for (int c = 1; c <= 6; c++) begin
      tick();
      checks++;
      if (mux_sel !== 2'd0 || cpu_grant !== 1'b1 || B_ADDR !== 14'h0123) begin
        errors++; $display("FAIL cpu_only c=%0d got mux=%0d grant=%b addr=%h want 0 1 0123", c, mux_sel, cpu_grant, B_ADDR);
      end
    end
  endtask

  task automatic test_flash_burst;
    logic [1:0] exp_mux;
    logic       exp_rdy;
    do_reset();
    fl_wvalid = 1; fl_addr = 14'h0010; fl_din = 16'h5a5a;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_mux = (c == 9 || c == 18) ? 2'd0 : 2'd1;
      exp_rdy = (c >= 2 && c != 10 && c != 19);
      checks++;
      if (mux_sel !== exp_mux || fl_wready !== exp_rdy || B_WR !== (exp_mux == 2'd1)) begin
        errors++; $display("FAIL flash_burst c=%0d got mux=%0d rdy=%b wr=%b want %0d %b %b",
                           c, mux_sel, fl_wready, B_WR, exp_mux, exp_rdy, exp_mux == 2'd1);
      end
      if (exp_mux == 2'd1) begin
        checks++;
        if (B_ADDR !== 14'h0010 || B_DIN !== 16'h5a5a || B_MASK !== 2'b11) begin
          errors++; $display("FAIL flash_bank c=%0d got %h %h %b want 0010 5a5a 11", c, B_ADDR, B_DIN, B_MASK);
        end
      end
    end
    fl_wvalid = 0;
    tick();
    checks++;
    if (mux_sel !== 2'd0 || fl_wready !== 1'b0) begin
      errors++; $display("FAIL flash_drop got mux=%0d rdy=%b want 0 0", mux_sel, fl_wready);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_mux;
    logic [2:0] exp_ack;
    do_reset();
    fl_wvalid = 1; bg_rvalid = 1; spr_rvalid = 1;
    fl_addr = 14'h0001; bg_addr = 14'h0202; spr_addr = 14'h0303;
    for (int c = 1; c <= 32; c++) begin
      tick();
      exp_mux = (c <= 8) ? 2'd1 : (c <= 16) ? 2'd2 : (c <= 24) ? 2'd3 : 2'd1;
      exp_ack = {(c >= 2 && c <= 9) || c >= 26, c >= 10 && c <= 17, c >= 18 && c <= 25};
      checks++;
      if (mux_sel !== exp_mux || {fl_wready, bg_rready, spr_rready} !== exp_ack) begin
        errors++; $display("FAIL round_robin c=%0d got mux=%0d acks=%b want %0d %b",
                           c, mux_sel, {fl_wready, bg_rready, spr_rready}, exp_mux, exp_ack);
      end
      if (c == 12 || c == 20) begin
        checks++;
        if (B_ADDR !== ((c == 12) ? 14'h0202 : 14'h0303) || B_WR !== 1'b0 || B_DIN !== 16'h0) begin
          errors++; $display("FAIL rr_bank c=%0d got addr=%h wr=%b din=%h", c, B_ADDR, B_WR, B_DIN);
        end
      end
    end
  endtask

  task automatic test_starvation;
    logic [1:0] exp_mux;
    logic       exp_grant;
    do_reset();
    bg_rvalid = 1; spr_rvalid = 1; cpu_req = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      exp_mux   = (c <= 8) ? 2'd2 : (c <= 16) ? 2'd3 : (c == 17) ? 2'd2 : (c == 18) ? 2'd0 : 2'd3;
      exp_grant = (c == 1 || c == 19);
      checks++;
      if (mux_sel !== exp_mux || cpu_grant !== exp_grant) begin
        errors++; $display("FAIL starvation c=%0d got mux=%0d grant=%b want %0d %b",
                           c, mux_sel, cpu_grant, exp_mux, exp_grant);
      end
    end
`ifdef SLURM16_BANK_SCHED_STATS_EN
    checks++;
    if (stat_force !== 8'd1 || stat_cpu_stall !== 16'd18) begin
      errors++; $display("FAIL stats got force=%0d stall=%0d want 1 18", stat_force, stat_cpu_stall);
    end
`endif
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    spr_rvalid = 1; spr_addr = 14'h1555;
    for (int c = 1; c <= 4; c++) tick();
    checks++;
    if (mux_sel !== 2'd3 || spr_rready !== 1'b1) begin
      errors++; $display("FAIL mid_burst_pre got mux=%0d rdy=%b want 3 1", mux_sel, spr_rready);
    end
    RST = 1;
    tick();
    checks++;
    if (mux_sel !== 2'd0 || {cpu_grant, fl_wready, bg_rready, spr_rready} !== 4'b0000) begin
      errors++; $display("FAIL mid_burst_rst got mux=%0d acks=%b want 0 0000",
                         mux_sel, {cpu_grant, fl_wready, bg_rready, spr_rready});
    end
    RST = 0;
    tick();
    checks++;
    if (mux_sel !== 2'd3 || spr_rready !== 1'b0) begin
      errors++; $display("FAIL mid_burst_regrant got mux=%0d rdy=%b want 3 0", mux_sel, spr_rready);
    end
    tick();
    checks++;
    if (spr_rready !== 1'b1 || B_ADDR !== 14'h1555) begin
      errors++; $display("FAIL mid_burst_ack got rdy=%b addr=%h want 1 1555", spr_rready, B_ADDR);
    end
  endtask

  task automatic test_expiry_and_force;
    logic [1:0] exp_mux;
    do_reset();
    bg_rvalid = 1; spr_rvalid = 1;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (c == 8) cpu_req = 1;
      exp_mux = (c <= 8) ? 2'd2 : (c <= 16) ? 2'd3 : (c <= 24) ? 2'd2 : (c == 25) ? 2'd0 : 2'd3;
      checks++;
      if (mux_sel !== exp_mux || cpu_grant !== (c == 26)) begin
        errors++; $display("FAIL expiry_force c=%0d got mux=%0d grant=%b want %0d %b",
                           c, mux_sel, cpu_grant, exp_mux, c == 26);
      end
    end
  endtask

  initial begin
    idle_inputs();
    RST = 1;
    test_cpu_only();
    test_flash_burst();
    test_round_robin();
    test_starvation();
    test_reset();
    test_reset_mid_burst();
    test_expiry_and_force();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
